// File: rtl/reg_wb_pkg.sv
// Shared register-writeback types: register addressing, writeback request
// record and a one-hot helper for scoreboard updates.
package reg_wb_pkg;

    localparam int NumRegs      = 32;
    localparam int RegAddrWidth = 5;
    localparam int WbDataWidth  = 32;

    typedef logic [RegAddrWidth-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t              rd;
        logic [WbDataWidth-1:0] data;
    } wb_req_t;

    function automatic logic [NumRegs-1:0] reg_bit(input reg_addr_t r);
        logic [NumRegs-1:0] one;
        one    = '0;
        one[r] = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of the writeback requester, register-file write and issue-claim
// signals around reg_wb_arbiter.
interface reg_wb_arbiter_if
    import reg_wb_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumReq    = 2
) ();

    // Handshake: a writeback moves when req_valid[k] and req_ready[k] are both
    // high at a rising clock edge; valid may not depend on ready, ready is one-hot
    // or zero, and an issue claim lands when issue_valid and issue_ready are high.
    logic [NumReq-1:0]                   req_valid;
    logic [NumReq-1:0][RegAddrWidth-1:0] req_rd;
    logic [NumReq-1:0][DataWidth-1:0]    req_data;
    logic [NumReq-1:0]                   req_ready;
    reg_addr_t                           wreg;
    logic [DataWidth-1:0]                wdata;
    logic                                we;
    logic                                issue_valid;
    reg_addr_t                           issue_rd;
    logic                                issue_ready;
    logic [NumRegs-1:0]                  pending;

    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd,
        input  req_ready, wreg, wdata, we, issue_ready, pending
    );

    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd,
        output req_ready, wreg, wdata, we, issue_ready, pending
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests, priority moves to the
// requester just after the last winner.
module rr_arbiter #(
    parameter int NumReq = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NumReq-1:0] i_req,
    output logic [NumReq-1:0] o_gnt
);

    localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrWidth-1:0] ptr_q;
    logic [PtrWidth-1:0] ptr_d;
    logic                found;
    int                  cur;

    // Scan offsets from the pointer; the first active request wins.
    always_comb begin
        o_gnt = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cur   = 0;
        for (int i = 0; i < NumReq; i++) begin
            cur = (int'(ptr_q) + i) % NumReq;
            for (int k = 0; k < NumReq; k++) begin
                if (!found && (k == cur) && i_req[k]) begin
                    found    = 1'b1;
                    o_gnt[k] = 1'b1;
                    ptr_d    = PtrWidth'((k + 1) % NumReq);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for a register file: merges requesters onto one write
// port and tracks which registers still await their writeback.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumReq    = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [NumReq-1:0]                   i_req_valid,
    input  logic [NumReq-1:0][RegAddrWidth-1:0] i_req_rd,
    input  logic [NumReq-1:0][DataWidth-1:0]    i_req_data,
    output logic [NumReq-1:0]                   o_req_ready,
    output reg_addr_t                           o_wreg,
    output logic [DataWidth-1:0]                o_wdata,
    output logic                                o_we,
    input  logic                                i_issue_valid,
    input  reg_addr_t                           i_issue_rd,
    output logic                                o_issue_ready,
    output logic [NumRegs-1:0]                  o_pending
);

    logic [NumReq-1:0]    arb_req;
    logic [NumReq-1:0]    arb_gnt;
    logic                 xfer;
    reg_addr_t            sel_rd;
    logic [DataWidth-1:0] sel_data;
    logic                 claim;

    logic                 we_q, we_d;
    reg_addr_t            wreg_q, wreg_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [NumRegs-1:0]   pending_q, pending_d;

    // Masking requests during reset keeps ready low, so nothing is accepted.
    always_comb begin
        arb_req = i_rst ? '0 : i_req_valid;
    end

    rr_arbiter #(
        .NumReq(NumReq)
    ) u_rr_arbiter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (arb_req),
        .o_gnt (arb_gnt)
    );

    always_comb begin
        xfer     = |arb_gnt;
        sel_rd   = '0;
        sel_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (arb_gnt[k]) begin
                sel_rd   = i_req_rd[k];
                sel_data = i_req_data[k];
            end
        end
    end

    // A transfer to r0 is consumed but never reaches the register file.
    always_comb begin
        we_d    = xfer && (sel_rd != '0);
        wreg_d  = xfer ? sel_rd : wreg_q;
        wdata_d = xfer ? sel_data : wdata_q;
    end

    always_comb begin
        o_issue_ready = !i_rst && ((i_issue_rd == '0) || !pending_q[i_issue_rd]);
        claim         = i_issue_valid && o_issue_ready && (i_issue_rd != '0);
    end

    // Clear first, then set: a claim landing with the retiring write wins.
    always_comb begin
        pending_d = pending_q;
        if (we_q) begin
            pending_d = pending_d & ~reg_bit(wreg_q);
        end
        if (claim) begin
            pending_d = pending_d | reg_bit(i_issue_rd);
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        o_req_ready = arb_gnt;
        o_we        = we_q;
        o_wreg      = wreg_q;
        o_wdata     = wdata_q;
        o_pending   = pending_q;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register data width.
REQ-002 SHALL have parameter NumReq, default 2, number of writeback requesters (range 2..4).
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port i_req_valid, input, NumReq, per-requester writeback valid.
REQ-006 SHALL have port i_req_rd, input, NumReq x 5, per-requester destination register.
REQ-007 SHALL have port i_req_data, input, NumReq x DataWidth, per-requester write data.
REQ-008 SHALL have port o_req_ready, output, NumReq, per-requester accept (one-hot or zero).
REQ-009 SHALL have ports o_wreg (output, 5), o_wdata (output, DataWidth), o_we (output, 1), driving the register file write port.
REQ-010 SHALL have ports i_issue_valid (input, 1) and i_issue_rd (input, 5), issue-stage claim of a destination register.
REQ-011 SHALL have port o_issue_ready, output, 1, claim accepted this cycle.
REQ-012 SHALL have port o_pending, output, 32, scoreboard: bit n set means register n awaits writeback.

Function
REQ-013 SHALL grant at most one requester per cycle, round-robin among those with i_req_valid high; o_req_ready combinational, high only for the granted requester.
REQ-014 SHALL advance round-robin priority after each transfer so that requester (g+1) mod NumReq is highest priority after grant to g; no grant means no pointer change.
REQ-015 SHALL define transfer as i_req_valid[k] and o_req_ready[k] both high at a rising edge.
REQ-016 SHALL register a transfer onto o_wreg/o_wdata with o_we=1 in the following cycle (latency 1); no transfer means o_we=0 next cycle, o_wreg/o_wdata hold.
REQ-017 SHALL accept a transfer with rd=0 but drive o_we=0 for it and leave o_pending unchanged.
REQ-018 SHALL sustain one write per cycle under continuous requests (no bubbles).
REQ-019 SHALL drive o_issue_ready = i_issue_rd==0 or o_pending[i_issue_rd]==0, independent of i_issue_valid.
REQ-020 SHALL set o_pending[i_issue_rd] at the edge where i_issue_valid, o_issue_ready are high and i_issue_rd!=0.
REQ-021 SHALL clear o_pending[o_wreg] at the edge where o_we is high (same edge the register file commits).
REQ-022 SHALL, when set and clear target the same register on one edge, leave the bit set.
REQ-023 SHALL hold o_pending[0] at 0 permanently.
REQ-024 SHALL leave o_pending unaffected by a writeback to a non-pending register.

Reset
REQ-025 SHALL, on i_rst high at a rising edge, force o_we=0, o_wreg=0, o_wdata=0, o_pending=0, priority pointer=0 (requester 0 highest).
REQ-026 SHALL drive o_req_ready all zero in every cycle i_rst is high; a request mid-handshake during reset is dropped, never written.
REQ-027 SHALL force o_issue_ready=0 in every cycle i_rst is high; no claim is recorded.

Structure
REQ-028 SHALL take from shared package reg_wb_pkg: constants NumRegs=32, RegAddrWidth=5, typedef reg_addr_t, and the writeback request struct (rd, data).
REQ-029 SHALL instantiate one sub-module rr_arbiter (NumReq-wide request vector in, one-hot grant out, internal pointer).
REQ-030 SHALL keep scoreboard and output register in reg_wb_arbiter itself.

Verification
REQ-031 Reset: i_rst=1 two cycles with all valids high -> o_req_ready=0, o_we=0, o_pending=0, o_issue_ready=0 throughout.
REQ-032 Round-robin: req0 and req1 valid continuously (rd 5 / 6, data 0xA / 0xB) -> grants 0,1,0,1; o_we=1 each cycle from cycle 2; o_wreg sequence 5,6,5,6.
REQ-033 rd zero: single req0 rd=0 data 0xFFFF_FFFF -> ready=1, next cycle o_we=0, o_pending unchanged.
REQ-034 Scoreboard: issue rd=7 -> o_pending[7]=1; second issue rd=7 -> o_issue_ready=0; req1 rd=7 data 0x1234 -> o_we=1 next cycle, bit 7 clears at that edge; o_issue_ready for rd 7 returns to 1.
REQ-035 Simultaneous: o_we=1 o_wreg=9 while issue rd=9 on same edge -> o_pending[9] remains 1.
REQ-036 Reset mid-operation: i_rst=1 while req0 valid and o_pending=0x0000_0080 -> o_pending=0, o_we=0 next cycle, then pointer restarts at requester 0.
